vram_swap_ctrl: RTL
===================

VRAM_SWAP_CTRL -- requirements
Module: vram_swap_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word address width of one VRAM buffer.
REQ-002 SHALL have parameter DATA_W, default 64, VRAM word width; byte-enable width is DATA_W/8.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port h2f_wraddr  in  ADDR_W  CPU write word address within the back buffer.
REQ-006 SHALL have port h2f_wren  in  1  CPU write strobe, one write per high cycle.
REQ-007 SHALL have port h2f_wrdata  in  DATA_W  CPU write data.
REQ-008 SHALL have port h2f_byteena  in  DATA_W/8  CPU byte enables.
REQ-009 SHALL have port h2f_wr_done  in  1  level from the CPU; a rising edge means the frame is complete.
REQ-010 SHALL have port vblank_start  in  1  one-cycle pulse from the PPU at vertical-blank start.
REQ-011 SHALL have port cpu_wr_busy  out  1  high while CPU writes are not accepted.
REQ-012 SHALL have port buf_sel  out  1  front buffer the PPU reads; the CPU writes bank ~buf_sel.
REQ-013 SHALL have port vram_wraddr  out  ADDR_W+1  VRAM write address, MSB = bank.
REQ-014 SHALL have port vram_wren  out  1  VRAM write strobe.
REQ-015 SHALL have port vram_wrdata  out  DATA_W  VRAM write data.
REQ-016 SHALL have port vram_byteena  out  DATA_W/8  VRAM byte enables.
REQ-017 SHALL have port vram_rdaddr  out  ADDR_W+1  VRAM copy read address, MSB = bank.
REQ-018 SHALL have port vram_rddata  in  DATA_W  VRAM read data, valid exactly 1 cycle after vram_rdaddr.
REQ-019 SHALL have port drop_err  out  1  sticky flag: a CPU write arrived while busy.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_VBLANK, SWAP, COPY.
REQ-021 In IDLE, an h2f_wren cycle SHALL produce vram_wren=1 one cycle later, with vram_wraddr={~buf_sel,h2f_wraddr} and data/byteena passed unchanged.
REQ-022 IDLE SHALL go to WAIT_VBLANK on a rising edge of h2f_wr_done (registered previous value); a write in that same cycle SHALL still be accepted.
REQ-023 WAIT_VBLANK SHALL go to SWAP on vblank_start; a vblank_start in IDLE, SWAP or COPY SHALL be ignored.
REQ-024 SWAP SHALL last 1 cycle, toggle buf_sel, clear the copy counter, and go to COPY.
REQ-025 COPY SHALL present vram_rdaddr={buf_sel,cnt} for cnt=0..2^ADDR_W-1, one per cycle.
REQ-026 COPY SHALL write {~buf_sel,cnt_d} with the returned vram_rddata and byteena all-ones, one cycle after each read; this makes the new back buffer equal to the new front buffer.
REQ-027 After the final copy write issues (cnt_d=2^ADDR_W-1), the FSM SHALL return to IDLE; a copy SHALL take 2^ADDR_W+1 cycles.
REQ-028 cpu_wr_busy SHALL be registered, high in WAIT_VBLANK, SWAP and COPY, and go low the cycle after the last copy write.
REQ-029 In any non-IDLE state, h2f_wren SHALL be discarded (no VRAM write) and drop_err SHALL set; drop_err SHALL clear only on reset.
REQ-030 In any non-IDLE state, further h2f_wr_done edges SHALL be ignored, not queued.
REQ-031 vram_wren SHALL never be asserted for both a CPU write and a copy write in the same cycle.
REQ-032 The counter SHALL be ADDR_W+1 bits so that the terminal condition does not wrap to 0.

Reset
REQ-033 On rst: state=IDLE, buf_sel=0, cpu_wr_busy=0, vram_wren=0, drop_err=0, all address/data/byteena outputs=0, counters=0, h2f_wr_done edge register=0.
REQ-034 rst asserted mid-COPY SHALL abandon the copy immediately with no further VRAM writes; buf_sel SHALL return to 0.

Verification
REQ-035 IDLE write: h2f_wraddr=0x0005, wrdata=0xDEADBEEF_01234567, byteena=0x0F, buf_sel=0 -> next cycle vram_wren=1, vram_wraddr=0x2005, same data, byteena=0x0F.
REQ-036 Frame swap: wr_done rises, vblank_start pulses 10 cycles later -> buf_sel toggles 0->1, cpu_wr_busy is high through COPY, and is low exactly 8193 cycles after SWAP.
REQ-037 Copy correctness: preload bank 1 with word value = address -> after COPY, bank 0 word k = k for all k in 0..8191, all byteena=0xFF.
REQ-038 Busy write: h2f_wren during WAIT_VBLANK -> no vram_wren, drop_err=1 and stays 1.
REQ-039 Boundary: vblank_start in IDLE -> no state change; wr_done edge plus h2f_wren in the same cycle -> write issued, then WAIT_VBLANK.
REQ-040 Reset mid-COPY at cnt=100 -> vram_wren=0 the same cycle, buf_sel=0, cpu_wr_busy=0, state IDLE.

Source files
------------

// File: rtl/vram_swap_ctrl.sv
// Double-buffered VRAM controller: CPU frame writes go to the back bank.
// At vblank the banks swap and the new front bank is copied into the new back bank.
module vram_swap_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     h2f_wraddr,
    input  logic                  h2f_wren,
    input  logic [DATA_W-1:0]     h2f_wrdata,
    input  logic [DATA_W/8-1:0]   h2f_byteena,
    input  logic                  h2f_wr_done,
    input  logic                  vblank_start,
    output logic                  cpu_wr_busy,
    output logic                  buf_sel,
    output logic [ADDR_W:0]       vram_wraddr,
    output logic                  vram_wren,
    output logic [DATA_W-1:0]     vram_wrdata,
    output logic [DATA_W/8-1:0]   vram_byteena,
    output logic [ADDR_W:0]       vram_rdaddr,
    input  logic [DATA_W-1:0]     vram_rddata,
    output logic                  drop_err
);

    typedef enum logic [1:0] {IDLE, WAIT_VBLANK, SWAP, COPY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                done_q;
    logic [ADDR_W:0]     cnt;
    logic [ADDR_W-1:0]   cnt_d;
    logic                vld_p1;
    logic                done_rise;
    logic                rd_issue;
    logic                copy_last;

    assign done_rise = h2f_wr_done & ~done_q;
    // Reads stop once the extra counter MSB sets, so the terminal count never wraps to 0.
    assign rd_issue  = (state == COPY) & ~cnt[ADDR_W];
    assign copy_last = (state == COPY) & vld_p1 & (&cnt_d);

    assign vram_rdaddr = rd_issue ? {buf_sel, cnt[ADDR_W-1:0]} : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (done_rise) state_nxt = WAIT_VBLANK;
            WAIT_VBLANK: if (vblank_start) state_nxt = SWAP;
            SWAP:        state_nxt = COPY;
            COPY:        if (copy_last) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            cpu_wr_busy <= 1'b0;
            buf_sel     <= 1'b0;
            cnt         <= '0;
            cnt_d       <= '0;
            vld_p1      <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            done_q      <= h2f_wr_done;
            cpu_wr_busy <= (state_nxt != IDLE);
            if (state == SWAP) begin
                buf_sel <= ~buf_sel;
                cnt     <= '0;
            end else if (rd_issue) begin
                cnt <= cnt + {{ADDR_W{1'b0}}, 1'b1};
            end
            // Read data returns one cycle after the address, so the index travels with it.
            vld_p1 <= rd_issue;
            if (rd_issue) cnt_d <= cnt[ADDR_W-1:0];
            if ((state != IDLE) && h2f_wren) drop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_wren    <= 1'b0;
            vram_wraddr  <= '0;
            vram_wrdata  <= '0;
            vram_byteena <= '0;
        end else begin
            vram_wren <= 1'b0;
            if ((state == IDLE) && h2f_wren) begin
                vram_wren    <= 1'b1;
                vram_wraddr  <= {~buf_sel, h2f_wraddr};
                vram_wrdata  <= h2f_wrdata;
                vram_byteena <= h2f_byteena;
            end else if ((state == COPY) && vld_p1) begin
                vram_wren    <= 1'b1;
                vram_wraddr  <= {~buf_sel, cnt_d};
                vram_wrdata  <= vram_rddata;
                vram_byteena <= '1;
            end
        end
    end

endmodule
